wallace_final_adder: RTL and testbench

WALLACE_FINAL_ADDER -- requirements
Module: wallace_final_adder

---
 rtl/wallace_final_adder_pkg.sv | 22 ++
 rtl/wallace_final_adder_cpa_seg.sv | 19 +
 rtl/wallace_final_adder.sv | 154 +++++++++++++++
 tb/tb_wallace_final_adder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_final_adder_pkg.sv
// Shared defaults and types for the Wallace-tree final carry-propagate adder.
// The stage struct is sized by the package defaults.
package wallace_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SEG_W_DEF = 16;
  localparam int NSEG_DEF  = WIDTH_DEF / SEG_W_DEF;
  localparam int TAG_W_DEF = 4;

  typedef logic [TAG_W_DEF-1:0] tag_t;
  typedef logic [NSEG_DEF-1:0]  seg_mask_t;

  // One pipeline stage: the valid flag, the carry out of the segment this
  // stage finished, the partially resolved sum, and the sideband tag.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [WIDTH_DEF-1:0] data;
    tag_t                 tag;
  } stage_t;

endpackage : wallace_pkg

// File: rtl/wallace_final_adder_cpa_seg.sv
// Combinational SEG_W-bit adder slice used once per pipeline stage.
module wallace_cpa_seg
  import wallace_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  // Plain ripple of one segment; the carry-out feeds the next stage's register.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  end

endmodule : wallace_cpa_seg

// File: rtl/wallace_final_adder.sv
// Pipelined final adder for a Wallace multiplier: resolves the carry-save
// pair (s_sum, s_carry) one SEG_W segment per stage, NSEG stages deep, with a
// valid/ready handshake on both sides and collapsing bubbles.
// Optional feature: define WALLACE_FINAL_ADDER_ZERO_FLAG_EN to add m_zero,
// a registered flag that is 1 when m_prod is zero.
module wallace_final_adder
  import wallace_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_sum,
  input  logic [WIDTH-1:0] s_carry,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_prod,
  output logic [TAG_W-1:0] m_tag
`ifdef WALLACE_FINAL_ADDER_ZERO_FLAG_EN
  ,
  output logic             m_zero
`endif
);

  localparam int NSEG = WIDTH / SEG_W;

  // Stage registers; the raw carry vector travels alongside so that the
  // still-unresolved upper segments have both addends available later.
  stage_t           r_stage [NSEG];
  logic [WIDTH-1:0] r_car   [NSEG];

  logic [NSEG-1:0]             w_load;
  logic                        w_gap;
  logic [NSEG-1:0]             w_in_valid;
  logic [NSEG-1:0]             w_in_cin;
  logic [NSEG-1:0]             w_seg_cout;
  logic [NSEG-1:0][WIDTH-1:0]  w_in_sum;
  logic [NSEG-1:0][WIDTH-1:0]  w_in_car;
  logic [NSEG-1:0][WIDTH-1:0]  w_next_sum;
  logic [NSEG-1:0][TAG_W-1:0]  w_in_tag;
  logic [NSEG-1:0][SEG_W-1:0]  w_seg_a;
  logic [NSEG-1:0][SEG_W-1:0]  w_seg_b;
  logic [NSEG-1:0][SEG_W-1:0]  w_seg_sum;
  logic                        w_unused_cout;

  // Select each stage's input: upstream port for stage 0, previous stage otherwise.
  always_comb begin
    w_in_valid = '0;
    w_in_cin   = '0;
    w_in_sum   = '0;
    w_in_car   = '0;
    w_in_tag   = '0;
    w_seg_a    = '0;
    w_seg_b    = '0;
    w_in_valid[0] = s_valid;
    w_in_sum[0]   = s_sum;
    w_in_car[0]   = s_carry;
    w_in_tag[0]   = s_tag;
    w_in_cin[0]   = 1'b0;
    for (int k = 1; k < NSEG; k++) begin
      w_in_valid[k] = r_stage[k-1].valid;
      w_in_sum[k]   = r_stage[k-1].data;
      w_in_car[k]   = r_car[k-1];
      w_in_tag[k]   = r_stage[k-1].tag;
      w_in_cin[k]   = r_stage[k-1].carry;
    end
    for (int k = 0; k < NSEG; k++) begin
      w_seg_a[k] = w_in_sum[k][k*SEG_W +: SEG_W];
      w_seg_b[k] = w_in_car[k][k*SEG_W +: SEG_W];
    end
  end

  // Load enables: a stage loads if it, or any stage after it, is empty, or the sink takes data.
  always_comb begin
    w_gap  = 1'b0;
    w_load = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      w_gap     = w_gap | ~r_stage[k].valid;
      w_load[k] = m_ready | w_gap;
    end
  end

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    wallace_cpa_seg #(
      .SEG_W (SEG_W)
    ) u_cpa (
      .a    (w_seg_a[g]),
      .b    (w_seg_b[g]),
      .cin  (w_in_cin[g]),
      .sum  (w_seg_sum[g]),
      .cout (w_seg_cout[g])
    );
  end

  // Splice each stage's freshly added segment into the partial sum it forwards.
  always_comb begin
    w_next_sum = w_in_sum;
    for (int k = 0; k < NSEG; k++) begin
      w_next_sum[k][k*SEG_W +: SEG_W] = w_seg_sum[k];
    end
  end

  // The final carry-out is the discarded bit WIDTH of the sum.
  assign w_unused_cout = w_seg_cout[NSEG-1];

  // Stage pipeline; data only updates when a valid item moves in, so a stalled
  // or drained output keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        r_stage[k] <= '0;
        r_car[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (w_load[k]) begin
          r_stage[k].valid <= w_in_valid[k];
          if (w_in_valid[k]) begin
            r_stage[k].data  <= w_next_sum[k];
            r_stage[k].carry <= w_seg_cout[k];
            r_stage[k].tag   <= w_in_tag[k];
            r_car[k]         <= w_in_car[k];
          end
        end
      end
    end
  end

  assign s_ready = rst_n & w_load[0];
  assign m_valid = r_stage[NSEG-1].valid;
  assign m_prod  = r_stage[NSEG-1].data;
  assign m_tag   = r_stage[NSEG-1].tag;

`ifdef WALLACE_FINAL_ADDER_ZERO_FLAG_EN
  logic r_zero;

  // Zero flag registered in step with the last stage's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (w_load[NSEG-1] && w_in_valid[NSEG-1]) begin
      r_zero <= (w_next_sum[NSEG-1] == {WIDTH{1'b0}});
    end
  end

  assign m_zero = r_zero;
`endif

endmodule : wallace_final_adder

// File: tb/tb_wallace_final_adder.sv
// Self-checking bench for wallace_final_adder: directed steps plus a random
// stream, scored against a queue model computing (sum + carry) mod 2^64.
module tb_wallace_final_adder;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_sum;
  logic [63:0] s_carry;
  logic [3:0]  s_tag;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_prod;
  logic [3:0]  m_tag;
`ifdef WALLACE_FINAL_ADDER_ZERO_FLAG_EN
  logic        m_zero;
`endif

  int          n_cmp;
  int          n_fail;
  logic [63:0] q_prod[$];
  logic [3:0]  q_tag[$];
  logic        last_s_fire;
  logic        hold_vld;
  logic [63:0] held_prod;
  logic [3:0]  held_tag;
  logic [63:0] exp_prod;
  int          lat;
  int          idx;
  int          cnt;

  wallace_final_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sum   (s_sum),
    .s_carry (s_carry),
    .s_tag   (s_tag),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_prod  (m_prod),
    .m_tag   (m_tag)
`ifdef WALLACE_FINAL_ADDER_ZERO_FLAG_EN
    ,
    .m_zero  (m_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes just before the edge, score, then advance.
  task automatic cyc();
    logic m_fire;
    logic [63:0] ep;
    logic [3:0]  et;
    #1;
    last_s_fire = s_valid && s_ready;
    m_fire      = m_valid && m_ready;
    if (hold_vld) begin
      chk("stall_valid", {63'd0, m_valid}, 64'd1);
      chk("stall_prod", m_prod, held_prod);
      chk("stall_tag", {60'd0, m_tag}, {60'd0, held_tag});
    end
    if (m_fire) begin
      if (q_prod.size() == 0) begin
        chk("unexpected_out", 64'(q_prod.size()), 64'd1);
      end else begin
        ep = q_prod.pop_front();
        et = q_tag.pop_front();
        chk("out_prod", m_prod, ep);
        chk("out_tag", {60'd0, m_tag}, {60'd0, et});
      end
    end
    if (last_s_fire) begin
      q_prod.push_back(s_sum + s_carry);
      q_tag.push_back(s_tag);
    end
    hold_vld  = m_valid && !m_ready;
    held_prod = m_prod;
    held_tag  = m_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one pair with the sink ready and wait for its result to show up.
  task automatic send_wait(input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    s_sum   = a;
    s_carry = b;
    s_tag   = t;
    s_valid = 1'b1;
    m_ready = 1'b1;
    cyc();
    chk("send_accept", {63'd0, last_s_fire}, 64'd1);
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    cnt = 0;
    while (q_prod.size() != 0 && cnt < 40) begin
      cyc();
      cnt++;
    end
    cyc();
    chk("drain_empty", 64'(q_prod.size()), 64'd0);
  endtask

  task automatic rand_pair();
    s_sum   = {$urandom, $urandom};
    s_carry = {$urandom, $urandom} & ~64'd1;
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    hold_vld = 1'b0;
    rst_n    = 1'b0;
    s_valid  = 1'b1;
    s_sum    = 64'd5;
    s_carry  = 64'd6;
    s_tag    = 4'd1;
    m_ready  = 1'b0;

    // Reset state with upstream valid asserted.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_prod", m_prod, 64'd0);
    chk("rst_m_tag", {60'd0, m_tag}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("rel_s_ready", {63'd0, s_ready}, 64'd1);

    // Single op across the 32-bit boundary.
    send_wait(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0002, 4'd3);
    chk("single_prod", m_prod, 64'h0000_0001_0000_0001);
    chk("single_tag", {60'd0, m_tag}, 64'd3);
`ifdef WALLACE_FINAL_ADDER_ZERO_FLAG_EN
    chk("single_zero", {63'd0, m_zero}, 64'd0);
`endif
    cyc();

    // Carry ripples through every segment, top carry-out dropped.
    send_wait(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 4'd7);
    chk("xcarry_prod", m_prod, 64'h0000_0000_0000_0001);
    cyc();

    // Wraps to exactly zero.
    send_wait(64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0002, 4'd9);
    chk("wrap_zero_prod", m_prod, 64'd0);
`ifdef WALLACE_FINAL_ADDER_ZERO_FLAG_EN
    chk("wrap_zero_flag", {63'd0, m_zero}, 64'd1);
`endif
    cyc();
    drain();

    // Random stream with random source and sink gaps.
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      rand_pair();
      s_tag   = 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    // Back-pressure: fill with the sink stalled, then release while still sending.
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1;
      s_tag   = 4'(idx);
      if (c == 0 || last_s_fire) rand_pair();
      cyc();
      if (last_s_fire) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd4);
    rand_pair();
    s_tag = 4'(idx);
    #1;
    chk("bp_s_ready_low", {63'd0, s_ready}, 64'd0);
    repeat (3) cyc();
    m_ready = 1'b1;
    #1;
    chk("bp_same_cycle_accept", {63'd0, s_ready}, 64'd1);
    cnt = 0;
    while (idx < 6 && cnt < 10) begin
      s_tag = 4'(idx);
      cyc();
      if (last_s_fire) begin
        idx++;
        rand_pair();
      end
      cnt++;
    end
    chk("bp_all_sent", 64'(idx), 64'd6);
    drain();

    // Bubble collapse with the sink stalled.
    m_ready = 1'b0;
    rand_pair();
    s_tag   = 4'd10;
    s_valid = 1'b1;
    cyc();
    chk("bub_a_accept", {63'd0, last_s_fire}, 64'd1);
    s_valid = 1'b0;
    cyc();
    cyc();
    rand_pair();
    s_tag   = 4'd11;
    s_valid = 1'b1;
    #1;
    chk("bub_s_ready", {63'd0, s_ready}, 64'd1);
    cyc();
    chk("bub_b_accept", {63'd0, last_s_fire}, 64'd1);
    s_valid = 1'b0;
    repeat (4) cyc();
    m_ready = 1'b1;
    cyc();
    chk("bub_no_gap", {63'd0, m_valid}, 64'd1);
    chk("bub_b_tag", {60'd0, m_tag}, 64'd11);
    drain();

    // Reset with three ops in flight.
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_pair();
      s_tag   = 4'(i + 12);
      s_valid = 1'b1;
      cyc();
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("mid_rst_m_prod", m_prod, 64'd0);
    chk("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    q_prod.delete();
    q_tag.delete();
    hold_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (m_valid) cnt++;
    end
    chk("mid_rst_no_out", 64'(cnt), 64'd0);
    rand_pair();
    exp_prod = s_sum + s_carry;
    send_wait(s_sum, s_carry, 4'd5);
    chk("post_rst_prod", m_prod, exp_prod);
    chk("post_rst_tag", {60'd0, m_tag}, 64'd5);
    cyc();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_wallace_final_adder
